// File: rtl/id_ex_stage_if.sv
// Bus bundle between decode/regfile, the ID/EX register and the forwarding sources.
// The decode side drives the "master" modport and the ID/EX stage takes the "slave" modport.
interface id_ex_stage_if #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) ();
    logic            hold;
    logic            flush;
    logic            id_valid;
    logic [XLEN-1:0] id_pc;
    logic [RA_W-1:0] id_rs1;
    logic [RA_W-1:0] id_rs2;
    logic [RA_W-1:0] id_rd;
    logic [XLEN-1:0] id_rs1_data;
    logic [XLEN-1:0] id_rs2_data;
    logic [XLEN-1:0] id_imm;
    logic [3:0]      id_alu_op;
    logic [2:0]      id_src_sel;
    logic [2:0]      id_ctrl;
    logic            mem_reg_write;
    logic [RA_W-1:0] mem_rd;
    logic [XLEN-1:0] mem_result;
    logic            wb_reg_write;
    logic [RA_W-1:0] wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            load_use_stall;
    logic            ex_valid;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [3:0]      alu_op;
    logic [RA_W-1:0] ex_rd;
    logic [2:0]      ex_ctrl;
    logic [XLEN-1:0] ex_store_data;

    modport master (
        output hold, flush, id_valid, id_pc, id_rs1, id_rs2, id_rd,
               id_rs1_data, id_rs2_data, id_imm, id_alu_op, id_src_sel, id_ctrl,
               mem_reg_write, mem_rd, mem_result, wb_reg_write, wb_rd, wb_data,
        input  load_use_stall, ex_valid, alu_a, alu_b, alu_op, ex_rd, ex_ctrl,
               ex_store_data
    );

    modport slave (
        input  hold, flush, id_valid, id_pc, id_rs1, id_rs2, id_rd,
               id_rs1_data, id_rs2_data, id_imm, id_alu_op, id_src_sel, id_ctrl,
               mem_reg_write, mem_rd, mem_result, wb_reg_write, wb_rd, wb_data,
        output load_use_stall, ex_valid, alu_a, alu_b, alu_op, ex_rd, ex_ctrl,
               ex_store_data
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: latches decoded operands/control, forwards EX/MEM and MEM/WB
// results onto the ALU operands, and turns load-use hazards into bubbles.
module id_ex_stage #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    id_ex_stage_if.slave bus
);
    logic                      valid_q, valid_d;
    logic [XLEN-1:0]           pc_q, pc_d;
    logic [XLEN-1:0]           imm_q, imm_d;
    logic [RA_W-1:0]           rd_q, rd_d;
    logic [3:0]                alu_op_q, alu_op_d;
    logic                      a_sel_q, a_sel_d;
    logic [1:0]                b_sel_q, b_sel_d;
    logic [2:0]                ctrl_q, ctrl_d;
    logic [1:0][RA_W-1:0]      rs_q, rs_d;
    logic [1:0][XLEN-1:0]      data_q, data_d;

    logic [1:0][RA_W-1:0]      id_rs;
    logic [1:0][XLEN-1:0]      id_data;
    logic [1:0][XLEN-1:0]      cap_data;
    logic [1:0][XLEN-1:0]      fwd;
    logic                      stall;
    logic                      bubble;

    assign id_rs   = {bus.id_rs2, bus.id_rs1};
    assign id_data = {bus.id_rs2_data, bus.id_rs1_data};

    // Index 0 is rs1, index 1 is rs2; both operands share identical bypass/forward logic.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_operand
            always_comb begin
                cap_data[gi] = id_data[gi];
                if (bus.wb_reg_write && (bus.wb_rd != '0) && (bus.wb_rd == id_rs[gi])) begin
                    cap_data[gi] = bus.wb_data;
                end
            end

            // Youngest producer (EX/MEM) takes precedence over MEM/WB.
            always_comb begin
                fwd[gi] = data_q[gi];
                if (bus.mem_reg_write && (bus.mem_rd != '0) && (bus.mem_rd == rs_q[gi])) begin
                    fwd[gi] = bus.mem_result;
                end else if (bus.wb_reg_write && (bus.wb_rd != '0) && (bus.wb_rd == rs_q[gi])) begin
                    fwd[gi] = bus.wb_data;
                end
            end
        end
    endgenerate

    // Conservative: rs2 is compared even for instructions that never read it.
    always_comb begin
        stall = valid_q && ctrl_q[1] && (rd_q != '0) && bus.id_valid &&
                ((rd_q == bus.id_rs1) || (rd_q == bus.id_rs2));
    end

    assign bubble = bus.flush || (!bus.hold && stall);

    always_comb begin
        valid_d  = valid_q;
        pc_d     = pc_q;
        imm_d    = imm_q;
        rd_d     = rd_q;
        alu_op_d = alu_op_q;
        a_sel_d  = a_sel_q;
        b_sel_d  = b_sel_q;
        ctrl_d   = ctrl_q;
        rs_d     = rs_q;
        data_d   = data_q;
        if (bubble) begin
            valid_d  = 1'b0;
            pc_d     = '0;
            imm_d    = '0;
            rd_d     = '0;
            alu_op_d = 4'b0000;
            a_sel_d  = 1'b0;
            b_sel_d  = 2'b11;
            ctrl_d   = 3'b000;
            rs_d     = '0;
            data_d   = '0;
        end else if (!bus.hold) begin
            valid_d  = bus.id_valid;
            pc_d     = bus.id_pc;
            imm_d    = bus.id_imm;
            rd_d     = bus.id_rd;
            alu_op_d = bus.id_alu_op;
            a_sel_d  = bus.id_src_sel[2];
            b_sel_d  = bus.id_src_sel[1:0];
            ctrl_d   = bus.id_ctrl;
            rs_d     = id_rs;
            data_d   = cap_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            pc_q     <= '0;
            imm_q    <= '0;
            rd_q     <= '0;
            alu_op_q <= 4'b0000;
            a_sel_q  <= 1'b0;
            b_sel_q  <= 2'b00;
            ctrl_q   <= 3'b000;
            rs_q     <= '0;
            data_q   <= '0;
        end else begin
            valid_q  <= valid_d;
            pc_q     <= pc_d;
            imm_q    <= imm_d;
            rd_q     <= rd_d;
            alu_op_q <= alu_op_d;
            a_sel_q  <= a_sel_d;
            b_sel_q  <= b_sel_d;
            ctrl_q   <= ctrl_d;
            rs_q     <= rs_d;
            data_q   <= data_d;
        end
    end

    always_comb begin
        bus.alu_a = a_sel_q ? pc_q : fwd[0];
        unique case (b_sel_q)
            2'b00:   bus.alu_b = fwd[1];
            2'b01:   bus.alu_b = imm_q;
            2'b10:   bus.alu_b = pc_q;
            default: bus.alu_b = '0;
        endcase
    end

    assign bus.load_use_stall = stall;
    assign bus.ex_valid       = valid_q;
    assign bus.alu_op         = alu_op_q;
    assign bus.ex_rd          = rd_q;
    assign bus.ex_ctrl        = ctrl_q;
    assign bus.ex_store_data  = fwd[1];

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a table of single-instruction vectors plus hand-written
// sequences for reset, forwarding priority, load-use bubbles and hold/flush.
module tb_id_ex_stage;
    localparam int XLEN = 32;
    localparam int RA_W = 5;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    id_ex_stage_if #(.XLEN(XLEN), .RA_W(RA_W)) bus ();

    id_ex_stage #(.XLEN(XLEN), .RA_W(RA_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] imm;
        logic [3:0]  op;
        logic [2:0]  src;
        logic [2:0]  ctrl;
        logic        cap_wb;
        logic [4:0]  cap_wb_rd;
        logic [31:0] cap_wb_data;
        logic        p_mem_rw;
        logic [4:0]  p_mem_rd;
        logic [31:0] p_mem_res;
        logic        p_wb_rw;
        logic [4:0]  p_wb_rd;
        logic [31:0] p_wb_data;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        logic [31:0] exp_st;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.hold = 1'b0;  bus.flush = 1'b0;  bus.id_valid = 1'b0;
        bus.id_pc = '0;   bus.id_rs1 = '0;   bus.id_rs2 = '0;  bus.id_rd = '0;
        bus.id_rs1_data = '0; bus.id_rs2_data = '0; bus.id_imm = '0;
        bus.id_alu_op = '0; bus.id_src_sel = '0; bus.id_ctrl = '0;
        bus.mem_reg_write = 1'b0; bus.mem_rd = '0; bus.mem_result = '0;
        bus.wb_reg_write = 1'b0;  bus.wb_rd = '0;  bus.wb_data = '0;
    endtask

    task automatic drive_id(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                            input logic [31:0] imm, input logic [3:0] op, input logic [2:0] src,
                            input logic [2:0] ctrl);
        bus.id_valid = 1'b1; bus.id_pc = pc; bus.id_rs1 = rs1; bus.id_rs2 = rs2; bus.id_rd = rd;
        bus.id_rs1_data = d1; bus.id_rs2_data = d2; bus.id_imm = imm;
        bus.id_alu_op = op; bus.id_src_sel = src; bus.id_ctrl = ctrl;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        idle_inputs();

        //        pc        rs1 rs2 rd  d1            d2          imm           op    src     ctrl    cwb  crd cdata         mrw mrd mres       wrw wrd wdata      exp_a         exp_b         exp_st
        vecs[0] = '{32'h40,  1,  2,  3, 32'h10,       32'h20,     32'h4,        4'd0, 3'b000, 3'b100, 0,   0,  0,            0,  0,  0,         0,  0,  0,         32'h10,       32'h20,       32'h20};
        vecs[1] = '{32'h100, 0,  0,  5, 32'h0,        32'h0,      32'h1000,     4'd2, 3'b101, 3'b100, 0,   0,  0,            0,  0,  0,         0,  0,  0,         32'h100,      32'h1000,     32'h0};
        vecs[2] = '{32'h44,  4,  6,  2, 32'h7,        32'h99,     32'hFFFFFFFC, 4'd1, 3'b001, 3'b100, 0,   0,  0,            0,  0,  0,         0,  0,  0,         32'h7,        32'hFFFFFFFC, 32'h99};
        vecs[3] = '{32'h200, 4,  6,  1, 32'h8,        32'h5,      32'h0,        4'd3, 3'b010, 3'b100, 0,   0,  0,            0,  0,  0,         0,  0,  0,         32'h8,        32'h200,      32'h5};
        vecs[4] = '{32'h300, 4,  6,  1, 32'h9,        32'h6,      32'h12,       4'd4, 3'b011, 3'b001, 0,   0,  0,            0,  0,  0,         0,  0,  0,         32'h9,        32'h0,        32'h6};
        vecs[5] = '{32'h50,  3,  0,  4, 32'h0,        32'h0,      32'h0,        4'd0, 3'b000, 3'b100, 1,   3,  32'hDEADBEEF, 0,  0,  0,         0,  0,  0,         32'hDEADBEEF, 32'h0,        32'h0};
        vecs[6] = '{32'h54,  1,  8,  4, 32'h3,        32'h1,      32'h0,        4'd0, 3'b000, 3'b001, 0,   0,  0,            1,  8,  32'hAAAA,  0,  0,  0,         32'h3,        32'hAAAA,     32'hAAAA};
        vecs[7] = '{32'h58,  1,  8,  4, 32'h3,        32'h1,      32'h0,        4'd0, 3'b000, 3'b001, 0,   0,  0,            0,  8,  32'hAAAA,  1,  8,  32'hBBBB,  32'h3,        32'hBBBB,     32'hBBBB};

        rst_n = 1'b0;
        #12;
        check("reset ex_valid", {31'b0, bus.ex_valid}, 32'h0);
        check("reset alu_a", bus.alu_a, 32'h0);
        check("reset alu_b", bus.alu_b, 32'h0);
        check("reset store", bus.ex_store_data, 32'h0);
        check("reset ex_ctrl", {29'b0, bus.ex_ctrl}, 32'h0);
        rst_n = 1'b1;
        step();

        // Async reset mid-cycle after loading an add
        drive_id(32'h40, 5'd1, 5'd2, 5'd3, 32'h77, 32'h88, 32'h0, 4'd0, 3'b000, 3'b100);
        step();
        bus.id_valid = 1'b0;
        check("add loaded ex_valid", {31'b0, bus.ex_valid}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("async rst ex_valid", {31'b0, bus.ex_valid}, 32'h0);
        check("async rst ex_ctrl", {29'b0, bus.ex_ctrl}, 32'h0);
        check("async rst alu_op", {28'b0, bus.alu_op}, 32'h0);
        check("async rst alu_a", bus.alu_a, 32'h0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 8; i++) begin
            idle_inputs();
            drive_id(vecs[i].pc, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].d1, vecs[i].d2,
                     vecs[i].imm, vecs[i].op, vecs[i].src, vecs[i].ctrl);
            bus.wb_reg_write = vecs[i].cap_wb;
            bus.wb_rd        = vecs[i].cap_wb_rd;
            bus.wb_data      = vecs[i].cap_wb_data;
            step();
            bus.id_valid      = 1'b0;
            bus.mem_reg_write = vecs[i].p_mem_rw;
            bus.mem_rd        = vecs[i].p_mem_rd;
            bus.mem_result    = vecs[i].p_mem_res;
            bus.wb_reg_write  = vecs[i].p_wb_rw;
            bus.wb_rd         = vecs[i].p_wb_rd;
            bus.wb_data       = vecs[i].p_wb_data;
            #1;
            check($sformatf("vec%0d alu_a", i), bus.alu_a, vecs[i].exp_a);
            check($sformatf("vec%0d alu_b", i), bus.alu_b, vecs[i].exp_b);
            check($sformatf("vec%0d store", i), bus.ex_store_data, vecs[i].exp_st);
            check($sformatf("vec%0d alu_op", i), {28'b0, bus.alu_op}, {28'b0, vecs[i].op});
            check($sformatf("vec%0d ex_rd", i), {27'b0, bus.ex_rd}, {27'b0, vecs[i].rd});
            check($sformatf("vec%0d ex_ctrl", i), {29'b0, bus.ex_ctrl}, {29'b0, vecs[i].ctrl});
            check($sformatf("vec%0d ex_valid", i), {31'b0, bus.ex_valid}, 32'h1);
        end

        // Forwarding priority on rs1 = x5, then x0 never forwarded
        idle_inputs();
        drive_id(32'h60, 5'd5, 5'd0, 5'd6, 32'h0, 32'h0, 32'h0, 4'd0, 3'b000, 3'b100);
        step();
        bus.id_valid = 1'b0;
        bus.mem_reg_write = 1'b1; bus.mem_rd = 5'd5; bus.mem_result = 32'h11;
        bus.wb_reg_write  = 1'b1; bus.wb_rd  = 5'd5; bus.wb_data    = 32'h22;
        #1 check("fwd mem wins", bus.alu_a, 32'h11);
        bus.mem_reg_write = 1'b0;
        #1 check("fwd wb", bus.alu_a, 32'h22);
        idle_inputs();
        drive_id(32'h64, 5'd0, 5'd0, 5'd6, 32'h0, 32'h0, 32'h0, 4'd0, 3'b000, 3'b100);
        step();
        bus.id_valid = 1'b0;
        bus.mem_reg_write = 1'b1; bus.mem_rd = 5'd0; bus.mem_result = 32'h55;
        bus.wb_reg_write  = 1'b1; bus.wb_rd  = 5'd0; bus.wb_data    = 32'h55;
        #1 check("x0 not fwd", bus.alu_a, 32'h0);

        // Load-use: load to x7 in EX, dependent rs2=x7 in ID
        idle_inputs();
        drive_id(32'h70, 5'd1, 5'd0, 5'd7, 32'h4, 32'h0, 32'h8, 4'd0, 3'b001, 3'b110);
        step();
        drive_id(32'h74, 5'd1, 5'd7, 5'd8, 32'h1, 32'h2, 32'h0, 4'd0, 3'b000, 3'b100);
        #1 check("load_use stall", {31'b0, bus.load_use_stall}, 32'h1);
        step();
        check("bubble ex_valid", {31'b0, bus.ex_valid}, 32'h0);
        check("bubble ex_ctrl", {29'b0, bus.ex_ctrl}, 32'h0);
        check("bubble alu_b", bus.alu_b, 32'h0);
        check("stall drops", {31'b0, bus.load_use_stall}, 32'h0);
        step();
        bus.id_valid = 1'b0;
        check("dep loaded valid", {31'b0, bus.ex_valid}, 32'h1);
        check("dep loaded ex_rd", {27'b0, bus.ex_rd}, 32'h8);

        // Hold keeps EX constant; flush overrides hold
        idle_inputs();
        drive_id(32'h80, 5'd1, 5'd2, 5'd9, 32'h1234, 32'h0, 32'h0, 4'd3, 3'b000, 3'b100);
        step();
        bus.hold = 1'b1;
        for (int c = 0; c < 3; c++) begin
            drive_id(32'h90 + c, 5'd10 + 5'(c), 5'd11, 5'd12 + 5'(c), 32'hF0 + c, 32'h1, 32'h2,
                     4'd5, 3'b001, 3'b001);
            step();
            check($sformatf("hold%0d alu_a", c), bus.alu_a, 32'h1234);
            check($sformatf("hold%0d ex_rd", c), {27'b0, bus.ex_rd}, 32'h9);
            check($sformatf("hold%0d alu_op", c), {28'b0, bus.alu_op}, 32'h3);
        end
        bus.flush = 1'b1;
        step();
        check("flush+hold valid", {31'b0, bus.ex_valid}, 32'h0);
        check("flush+hold alu_a", bus.alu_a, 32'h0);
        check("flush+hold alu_op", {28'b0, bus.alu_op}, 32'h0);
        idle_inputs();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
